// File: rtl/masker_osel_pipe.sv
// Two-stage bit-field masker with output select (mask/merge, ALU shifts, Q funnel).
// Optional internal Q register enabled by defining MASKER_OSEL_QREG_EN.
module masker_osel_pipe #(
  parameter int W  = 32,
  parameter int LW = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [LW-1:0] mleft,
  input  logic [LW-1:0] mright,
  input  logic [W-1:0]  r,
  input  logic [W-1:0]  a,
  input  logic [W:0]    alu,
  input  logic [W-1:0]  q_in,
  input  logic [1:0]    osel,
  input  logic [1:0]    qctl,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  ob
`ifdef MASKER_OSEL_QREG_EN
  ,
  output logic [W-1:0]  q
`endif
);

  // Out-of-range indices clamp to the top bit; mright > mleft selects a wrapped field.
  function automatic logic [W-1:0] f_mask(input logic [LW-1:0] ml_raw, input logic [LW-1:0] mr_raw);
    logic [W-1:0] m;
    int ml;
    int mr;
    ml = (int'(ml_raw) >= W) ? (W - 1) : int'(ml_raw);
    mr = (int'(mr_raw) >= W) ? (W - 1) : int'(mr_raw);
    m  = {W{1'b0}};
    for (int i = 0; i < W; i++) begin
      if (mr <= ml) begin
        m[i] = (i >= mr) && (i <= ml);
      end else begin
        m[i] = (i >= mr) || (i <= ml);
      end
    end
    return m;
  endfunction

  logic          w_advance;
  logic [W-1:0]  w_mo;
  logic [W-1:0]  w_qsrc;
  logic [W-1:0]  w_ob;
  logic          w_unused;

  logic          r_s1_valid;
  logic [W-1:0]  r_s1_mask;
  logic [W-1:0]  r_s1_r;
  logic [W-1:0]  r_s1_a;
  logic [W:0]    r_s1_alu;
  logic [1:0]    r_s1_osel;
  logic          r_out_valid;
  logic [W-1:0]  r_ob;

  assign w_advance = ~r_out_valid | out_ready;
  assign in_ready  = w_advance;
  assign out_valid = r_out_valid;
  assign ob        = r_ob;

`ifdef MASKER_OSEL_QREG_EN
  logic [1:0]    r_s1_qctl;
  logic [W-1:0]  r_q;
  logic [W-1:0]  w_q_next;

  assign q        = r_q;
  assign w_qsrc   = r_q;
  assign w_unused = ^q_in;

  // Q update for the set leaving stage 1, based on that set's ALU result
  always_comb begin
    w_q_next = r_q;
    case (r_s1_qctl)
      2'b01:   w_q_next = {r_q[W-2:0], ~r_s1_alu[W-1]};
      2'b10:   w_q_next = {r_s1_alu[0], r_q[W-1:1]};
      2'b11:   w_q_next = r_s1_alu[W-1:0];
      default: w_q_next = r_q;
    endcase
  end

  // Q register and its stage-1 control field
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q       <= {W{1'b0}};
      r_s1_qctl <= 2'b00;
    end else begin
      if (w_advance && in_valid) begin
        r_s1_qctl <= qctl;
      end
      if (w_advance && r_s1_valid) begin
        r_q <= w_q_next;
      end
    end
  end
`else
  logic [W-1:0]  r_s1_qin;

  assign w_qsrc   = r_s1_qin;
  assign w_unused = ^qctl;

  // External Q value captured alongside the other operands
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_qin <= {W{1'b0}};
    end else if (w_advance && in_valid) begin
      r_s1_qin <= q_in;
    end
  end
`endif

  assign w_mo = (r_s1_mask & r_s1_r) | (~r_s1_mask & r_s1_a);

  // Output source select; osel=11 sees Q before this set's own update
  always_comb begin
    w_ob = w_mo;
    case (r_s1_osel)
      2'b00:   w_ob = w_mo;
      2'b01:   w_ob = r_s1_alu[W-1:0];
      2'b10:   w_ob = r_s1_alu[W:1];
      2'b11:   w_ob = {r_s1_alu[W-2:0], w_qsrc[W-1]};
      default: w_ob = w_mo;
    endcase
  end

  // Stage 1: operand and mask capture; a bubble is inserted when nothing is offered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_mask  <= {W{1'b0}};
      r_s1_r     <= {W{1'b0}};
      r_s1_a     <= {W{1'b0}};
      r_s1_alu   <= {(W+1){1'b0}};
      r_s1_osel  <= 2'b00;
    end else if (w_advance) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_mask <= f_mask(mleft, mright);
        r_s1_r    <= r;
        r_s1_a    <= a;
        r_s1_alu  <= alu;
        r_s1_osel <= osel;
      end
    end
  end

  // Stage 2: result register; ob keeps its last value across bubbles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_ob        <= {W{1'b0}};
    end else if (w_advance) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_ob <= w_ob;
      end
    end
  end

endmodule

// File: tb/tb_masker_osel_pipe.sv
// Scoreboard bench for masker_osel_pipe: driver queues expected ob, monitor pops on each handshake.
module tb_masker_osel_pipe;
  localparam int W  = 32;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [LW-1:0] mleft = '0;
  logic [LW-1:0] mright = '0;
  logic [W-1:0]  r = '0;
  logic [W-1:0]  a = '0;
  logic [W:0]    alu = '0;
  logic [W-1:0]  q_in = '0;
  logic [1:0]    osel = 2'b00;
  logic [1:0]    qctl = 2'b00;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  ob;
`ifdef MASKER_OSEL_QREG_EN
  logic [W-1:0]  q;
`endif

  masker_osel_pipe #(.W(W), .LW(LW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .mleft(mleft), .mright(mright), .r(r), .a(a), .alu(alu), .q_in(q_in),
    .osel(osel), .qctl(qctl), .out_valid(out_valid), .out_ready(out_ready), .ob(ob)
`ifdef MASKER_OSEL_QREG_EN
    , .q(q)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] held = '0;
  bit prev_stall = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Offer one operand set; the expected ob is queued once acceptance is certain.
  task automatic send(input logic [LW-1:0] ml, input logic [LW-1:0] mr, input logic [W-1:0] rv,
                      input logic [W-1:0] av, input logic [W:0] aluv, input logic [W-1:0] qv,
                      input logic [1:0] os, input logic [1:0] qc, input logic [W-1:0] expv);
    int n = 0;
    @(negedge clk);
    mleft = ml; mright = mr; r = rv; a = av; alu = aluv; q_in = qv; osel = os; qctl = qc;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
    end else begin
      exp_q.push_back(expv);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", W'(exp_q.size()), '0);
  endtask

  // Monitor: compare on each handshake and verify ob/out_valid hold across stalls
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", W'(out_valid), W'(1));
        chk("stall_ob", ob, held);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %h, required no output", ob);
        end else begin
          chk("ob", ob, exp_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      held = ob;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_ob", ob, '0);
`ifdef MASKER_OSEL_QREG_EN
    chk("rst_q", q, '0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("rst_in_ready", W'(in_ready), W'(1));

    // Field mask 15..8 with exact two-stage latency
    send(5'd15, 5'd8, 32'hFFFFFFFF, 32'h0, 33'h0, 32'h0, 2'b00, 2'b00, 32'h0000FF00);
    chk("lat_stage1", W'(out_valid), '0);
    @(posedge clk);
    #1 chk("lat_stage2", W'(out_valid), W'(1));
    chk("lat_ob", ob, 32'h0000FF00);
    drain();

    send(5'd3, 5'd28, 32'hFFFFFFFF, 32'h0, 33'h0, 32'h0, 2'b00, 2'b00, 32'hF000000F);
    send(5'd7, 5'd0, 32'h12345678, 32'hABCDEF00, 33'h0, 32'h0, 2'b00, 2'b00, 32'hABCDEF78);
    send(5'd5, 5'd5, 32'hFFFFFFFF, 32'h0, 33'h0, 32'h0, 2'b00, 2'b00, 32'h00000020);
    send(5'd31, 5'd0, 32'hA5A5A5A5, 32'h5A5A5A5A, 33'h0, 32'h0, 2'b00, 2'b00, 32'hA5A5A5A5);
    send(5'd0, 5'd31, 32'h0, 32'hFFFFFFFF, 33'h0, 32'h0, 2'b00, 2'b00, 32'h7FFFFFFE);
    send(5'd0, 5'd0, 32'h0, 32'h0, 33'h1_80000001, 32'h0, 2'b10, 2'b00, 32'hC0000000);
    send(5'd0, 5'd0, 32'h0, 32'h0, 33'h1_80000001, 32'h0, 2'b01, 2'b00, 32'h80000001);
`ifndef MASKER_OSEL_QREG_EN
    send(5'd0, 5'd0, 32'h0, 32'h0, 33'h1_80000001, 32'h80000000, 2'b11, 2'b11, 32'h00000003);
    send(5'd0, 5'd0, 32'h0, 32'h0, 33'h1_80000001, 32'h7FFFFFFF, 2'b11, 2'b01, 32'h00000002);
`endif
    drain();

`ifdef MASKER_OSEL_QREG_EN
    // Load Q, then funnel it in and shift it in the same set
    send(5'd0, 5'd0, 32'h0, 32'h0, 33'h0_80000000, 32'h0, 2'b01, 2'b11, 32'h80000000);
    send(5'd0, 5'd0, 32'h0, 32'h0, 33'h0_00000001, 32'hFFFFFFFF, 2'b11, 2'b01, 32'h00000003);
    drain();
    chk("q_after_shift", q, 32'h00000001);
`endif

    // Bubbles: out_valid drops, ob keeps the last result
    repeat (3) @(negedge clk);
    chk("bubble_valid", W'(out_valid), '0);
`ifdef MASKER_OSEL_QREG_EN
    chk("bubble_ob", ob, 32'h00000003);
`else
    chk("bubble_ob", ob, 32'h00000002);
`endif

    // Four back-to-back sets with a three-cycle consumer stall mid-stream
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          send(5'd0, 5'd0, 32'h0, 32'h0, {1'b0, 32'h11110000 + 32'(i)}, 32'h0, 2'b01, 2'b00,
               32'h11110000 + 32'(i));
        end
      end
      begin
        repeat (2) @(posedge clk);
        #2 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with both stages full: everything in flight is discarded
    @(negedge clk);
    out_ready = 1'b0;
    send(5'd0, 5'd0, 32'h0, 32'h0, 33'h0_DEADBEEF, 32'h0, 2'b01, 2'b00, 32'hDEADBEEF);
    send(5'd0, 5'd0, 32'h0, 32'h0, 33'h0_CAFEF00D, 32'h0, 2'b01, 2'b00, 32'hCAFEF00D);
    @(negedge clk);
    chk("full_valid", W'(out_valid), W'(1));
    chk("full_ob", ob, 32'hDEADBEEF);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_valid", W'(out_valid), '0);
    chk("midrst_ob", ob, '0);
    exp_q.delete();
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("no_stale_valid", W'(out_valid), '0);
    chk("no_stale_ob", ob, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/masker_osel_pipe.md
MASKER_OSEL_PIPE -- requirements
Module: masker_osel_pipe

Interface
REQ-001 SHALL have parameter W, default 32: datapath width; legal range 8..64.
REQ-002 SHALL have parameter LW, default 5: mask-field width; SHALL equal ceil(log2(W)).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operand set presented.
REQ-006 SHALL have port in_ready  output  1  operand set accepted when in_valid & in_ready.
REQ-007 SHALL have port mleft  input  LW  mask upper bit index.
REQ-008 SHALL have port mright  input  LW  mask lower bit index.
REQ-009 SHALL have port r  input  W  rotated M-side data.
REQ-010 SHALL have port a  input  W  A-side data.
REQ-011 SHALL have port alu  input  W+1  ALU result including carry bit W.
REQ-012 SHALL have port q_in  input  W  external Q value.
REQ-013 SHALL have port osel  input  2  output select.
REQ-014 SHALL have port qctl  input  2  Q control: 00 hold, 01 shift left, 10 shift right, 11 load.
REQ-015 SHALL have port out_valid  output  1  ob holds a result.
REQ-016 SHALL have port out_ready  input  1  consumer takes the result when out_valid & out_ready.
REQ-017 SHALL have port ob  output  W  selected output bus.
REQ-018 SHALL have port q  output  W  Q register; present only when the Configuration macro is defined.

Function
REQ-019 SHALL compute mask bit i = 1 for mright <= i <= mleft when mright <= mleft; when mright > mleft, mask bit i = 1 for i >= mright or i <= mleft (wrap).
REQ-020 SHALL treat index fields >= W as W-1.
REQ-021 SHALL form mo = (mask & r) | (~mask & a).
REQ-022 SHALL select ob source: 00 mo; 01 alu[W-1:0]; 10 alu[W:1]; 11 {alu[W-2:0], qsrc[W-1]}.
REQ-023 SHALL be a two-stage pipeline: stage 1 registers operands and mask; stage 2 registers ob. out_valid rises exactly 2 cycles after acceptance with no stall.
REQ-024 SHALL use a global advance = ~out_valid | out_ready; in_ready = advance; both stages load only on advance.
REQ-025 SHALL hold ob, out_valid and all stage-1 contents stable while out_valid & ~out_ready.
REQ-026 SHALL sustain one result per cycle with in_valid and out_ready held high.
REQ-027 SHALL clear the stage-1 valid bit on advance when in_valid is 0, creating a bubble; ob SHALL keep its last value when out_valid is 0.

Reset
REQ-028 SHALL on reset_n low immediately force out_valid=0, stage-1 valid=0, ob=0 and q=0; in_ready SHALL be 1 once reset_n is high.
REQ-029 SHALL discard any in-flight operand set on reset mid-operation; no result for it SHALL appear.

Configuration
REQ-030 SHALL, with MASKER_OSEL_QREG_EN defined, contain an internal W-bit Q register; qsrc = q.
REQ-031 SHALL update the Q register only when a valid operand set moves from stage 1 to stage 2, using that set's alu: 01 q <= {q[W-2:0], ~alu[W-1]}; 10 q <= {alu[0], q[W-1:1]}; 11 q <= alu[W-1:0].
REQ-032 SHALL, for osel=11, use the Q value before that set's own update.
REQ-033 SHALL, without MASKER_OSEL_QREG_EN, have no Q register and no q port; qsrc = q_in registered in stage 1; qctl SHALL be ignored.

Verification
REQ-034 SHALL cover: W=32, mleft=15, mright=8, r=FFFFFFFF, a=0, osel=00 -> ob=0000FF00 two cycles later.
REQ-035 SHALL cover: mleft=3, mright=28, r=FFFFFFFF, a=0 -> ob=F000000F (wrap).
REQ-036 SHALL cover: alu=1_80000001, osel=10 -> ob=C0000000; osel=01 -> ob=80000001.
REQ-037 SHALL cover, with the macro: load q=80000000 via qctl=11, then osel=11, alu=00000001 -> ob=00000003; with qctl=01 in the same set, q then becomes 00000001 (~alu[31]=1).
REQ-038 SHALL cover: 4 back-to-back sets with out_ready low for 3 cycles mid-stream -> no loss, no duplication, order preserved, ob stable while stalled.
REQ-039 SHALL cover: reset_n low with both stages full -> out_valid=0 and ob=0 immediately; no stale result after release.
